// File: rtl/console_pkg.sv
// console_pkg: shared types, geometry, control codes and address helper for the text console
package console_pkg;

   typedef enum logic [1:0] {IDLE, WRITE, CLEAR, LINECLR} state_t;

   localparam int COLS   = 64;
   localparam int ROWS   = 20;
   localparam int ADDR_W = 16;
   localparam int COL_W  = $clog2(COLS);
   localparam int ROW_W  = $clog2(ROWS);
   localparam int CELLS  = ROWS * COLS;

   localparam logic [7:0] BLANK = 8'h20;
   localparam logic [7:0] CH_BS = 8'h08;
   localparam logic [7:0] CH_LF = 8'h0A;
   localparam logic [7:0] CH_FF = 8'h0C;
   localparam logic [7:0] CH_CR = 8'h0D;

   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

   // COLS is a power of two, so row*COLS+col is just the concatenation
   function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c);
      return ADDR_W'({r, c});
   endfunction

endpackage

// File: rtl/console_clear_seq.sv
// console_clear_seq: base/length address walker used by full-screen and single-line clears
module console_clear_seq
   import console_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              step,
   input  logic [ADDR_W-1:0] base,
   input  logic [ADDR_W-1:0] len,
   output logic [ADDR_W-1:0] addr,
   output logic              done
);

   logic [ADDR_W-1:0] addr_q, addr_d, last_q, last_d;

   assign addr = addr_q;
   assign done = (addr_q == last_q);

   // load the range on start, advance one cell per granted step
   always_comb begin
      addr_d = start ? base : (step ? addr_q + 1'b1 : addr_q);
      last_d = start ? base + len - 1'b1 : last_q;
   end

   // state registers, cleared by the active-low synchronous reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         addr_q <= '0;
         last_q <= '0;
      end else begin
         addr_q <= addr_d;
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/text_console_ctrl.sv
// text_console_ctrl: cursor/control-code writer and read-priority arbiter for the text memory
// Optional per-row blanking on row advance is enabled by defining CONSOLE_LINE_CLEAR_EN.
module text_console_ctrl
   import console_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [7:0]        in_char,
   output logic              in_ready,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_grant,
   output logic              mem_ren,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_data,
   output logic [ROW_W-1:0]  cursor_row,
   output logic [COL_W-1:0]  cursor_col,
   output logic              busy
);

   state_t            state_q, state_d;
   logic [7:0]        char_q, char_d, data_q, data_d;
   logic [ROW_W-1:0]  row_q, row_d, row_inc;
   logic [COL_W-1:0]  col_q, col_d;
   logic [ADDR_W-1:0] addr_q, addr_d, seq_base, seq_len, seq_addr;
   logic              ren_q, ren_d, wen_q, wen_d, grant_q, grant_d, busy_q, busy_d;
   logic              seq_start, seq_step, seq_done, accept;

   assign in_ready   = (state_q == IDLE) && reset;
   assign accept     = in_valid && in_ready;
   assign row_inc    = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
   assign rd_grant   = grant_q;
   assign mem_ren    = ren_q;
   assign mem_wen    = wen_q;
   assign mem_addr   = addr_q;
   assign mem_data   = data_q;
   assign cursor_row = row_q;
   assign cursor_col = col_q;
   assign busy       = busy_q;

   console_clear_seq u_clear_seq (
      .clk   (clk),
      .reset (reset),
      .start (seq_start),
      .step  (seq_step),
      .base  (seq_base),
      .len   (seq_len),
      .addr  (seq_addr),
      .done  (seq_done)
   );

   // reads win every cycle; writes and clear steps only proceed when no read is requested
   always_comb begin
      state_d   = state_q;
      char_d    = char_q;
      row_d     = row_q;
      col_d     = col_q;
      addr_d    = addr_q;
      data_d    = data_q;
      ren_d     = rd_req;
      grant_d   = rd_req;
      wen_d     = 1'b0;
      seq_start = 1'b0;
      seq_step  = 1'b0;
      seq_base  = '0;
      seq_len   = ADDR_W'(CELLS);
      if (rd_req) addr_d = rd_addr;
      if (accept) begin
         char_d    = in_char;
         state_d   = (in_char == CH_FF) ? CLEAR : WRITE;
         seq_start = (in_char == CH_FF);
      end else if (state_q == WRITE && !rd_req) begin
         state_d = IDLE;
         if (char_q >= 8'h20 && char_q <= 8'h7E) begin
            wen_d  = 1'b1;
            addr_d = cell_addr(row_q, col_q);
            data_d = char_q;
            col_d  = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
            row_d  = (col_q == COL_LAST) ? row_inc : row_q;
         end else if (char_q == CH_LF) begin
            col_d = '0;
            row_d = row_inc;
         end else if (char_q == CH_CR) begin
            col_d = '0;
         end else if (char_q == CH_BS && col_q != '0) begin
            wen_d  = 1'b1;
            col_d  = col_q - 1'b1;
            addr_d = cell_addr(row_q, col_q - 1'b1);
            data_d = BLANK;
         end
`ifdef CONSOLE_LINE_CLEAR_EN
         if (row_d != row_q) begin
            state_d   = LINECLR;
            seq_start = 1'b1;
            seq_base  = cell_addr(row_d, '0);
            seq_len   = ADDR_W'(COLS);
         end
`endif
      end else if ((state_q == CLEAR || state_q == LINECLR) && !rd_req) begin
         seq_step = 1'b1;
         wen_d    = 1'b1;
         addr_d   = seq_addr;
         data_d   = BLANK;
         if (seq_done) begin
            state_d = IDLE;
            row_d   = (state_q == CLEAR) ? '0 : row_q;
            col_d   = (state_q == CLEAR) ? '0 : col_q;
         end
      end
      busy_d = (state_d == CLEAR) || (state_d == LINECLR);
   end

   // registered state and outputs, all zero under reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         char_q  <= '0;
         row_q   <= '0;
         col_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         ren_q   <= 1'b0;
         wen_q   <= 1'b0;
         grant_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         char_q  <= char_d;
         row_q   <= row_d;
         col_q   <= col_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         ren_q   <= ren_d;
         wen_q   <= wen_d;
         grant_q <= grant_d;
         busy_q  <= busy_d;
      end
   end

endmodule

// File: tb/tb_text_console_ctrl.sv
// tb_text_console_ctrl: directed self-checking bench for text_console_ctrl
module tb_text_console_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_char = 8'h00;
   logic        in_ready;
   logic        rd_req = 1'b0;
   logic [15:0] rd_addr = 16'h0000;
   logic        rd_grant, mem_ren, mem_wen, busy;
   logic [15:0] mem_addr;
   logic [7:0]  mem_data;
   logic [4:0]  cursor_row;
   logic [5:0]  cursor_col;

   int n_vec = 0;
   int n_err = 0;
   int both_n = 0;
   int rd_n = 0;
   logic [15:0] wa[$];
   logic [7:0]  wd[$];

   text_console_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_char    (in_char),
      .in_ready   (in_ready),
      .rd_req     (rd_req),
      .rd_addr    (rd_addr),
      .rd_grant   (rd_grant),
      .mem_ren    (mem_ren),
      .mem_wen    (mem_wen),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .cursor_row (cursor_row),
      .cursor_col (cursor_col),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // log every memory write and watch for read/write overlap
   always @(posedge clk) begin
      #1;
      if (mem_wen) begin
         wa.push_back(mem_addr);
         wd.push_back(mem_data);
      end
      if (mem_ren && mem_wen) both_n++;
      if (mem_ren && rd_grant && mem_addr == 16'h0100) rd_n++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_ren"}, 32'(mem_ren), 0);
      check({tag, "_wen"}, 32'(mem_wen), 0);
      check({tag, "_addr"}, 32'(mem_addr), 0);
      check({tag, "_data"}, 32'(mem_data), 0);
      check({tag, "_grant"}, 32'(rd_grant), 0);
      check({tag, "_row"}, 32'(cursor_row), 0);
      check({tag, "_col"}, 32'(cursor_col), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_ready"}, 32'(in_ready), 0);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      in_valid = 1'b0;
      rd_req = 1'b0;
      repeat (2) @(negedge clk);
      check_zero_outputs("rst");
      reset = 1'b1;
      @(negedge clk);
      wa.delete();
      wd.delete();
   endtask

   task automatic send(input logic [7:0] ch);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("send_ready_timeout", 32'(in_ready), 1);
      in_valid = 1'b1;
      in_char = ch;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(output int cyc, output int busy_n);
      cyc = 0;
      busy_n = 0;
      while (!in_ready && cyc < 5000) begin
         if (busy) busy_n++;
         @(negedge clk);
         cyc++;
      end
      if (!in_ready) check("idle_timeout", 32'(in_ready), 1);
   endtask

   task automatic put(input logic [7:0] ch);
      int c, b;
      send(ch);
      wait_idle(c, b);
   endtask

   task automatic check_cursor(input string tag, input int r, input int c);
      check({tag, "_row"}, 32'(cursor_row), 32'(r));
      check({tag, "_col"}, 32'(cursor_col), 32'(c));
   endtask

   task automatic check_blank_run(input string tag, input int base, input int len);
      int bad = 0;
      check({tag, "_count"}, 32'(wa.size()), 32'(len));
      for (int i = 0; i < wa.size() && i < len; i++)
         if (wa[i] != 16'(base + i) || wd[i] != 8'h20) bad++;
      check({tag, "_content"}, 32'(bad), 0);
   endtask

   initial begin
      int cyc, bn;
      logic [7:0] ch;
      // 1: reset, one printable character
      do_reset();
      put(8'h41);
      check("t1_nwr", 32'(wa.size()), 1);
      check("t1_addr", 32'(wa[0]), 0);
      check("t1_data", 32'(wd[0]), 32'h41);
      check_cursor("t1_cur", 0, 1);
      // 2: a full row then one more character
      do_reset();
      for (int i = 0; i < 64; i++) begin
         ch = 8'(8'h41 + i % 26);
         put(ch);
      end
      check("t2_nwr", 32'(wa.size()), 64);
      for (int i = 0; i < 64; i++) begin
         ch = 8'(8'h41 + i % 26);
         check("t2_addr", 32'(wa[i]), 32'(i));
         check("t2_data", 32'(wd[i]), 32'(ch));
      end
      check_cursor("t2_cur", 1, 0);
      wa.delete();
      wd.delete();
      put(8'h7E);
      check("t2_65_nwr", 32'(wa.size()), 1);
      check("t2_65_addr", 32'(wa[0]), 64);
      check("t2_65_data", 32'(wd[0]), 32'h7E);
      // 3: reads stall a pending write
      do_reset();
      both_n = 0;
      rd_n = 0;
      @(negedge clk);
      rd_req = 1'b1;
      rd_addr = 16'h0100;
      in_valid = 1'b1;
      in_char = 8'h5A;
      @(negedge clk);
      in_valid = 1'b0;
      check("t3_nwr_stalled", 32'(wa.size()), 0);
      repeat (2) @(negedge clk);
      rd_req = 1'b0;
      wait_idle(cyc, bn);
      @(negedge clk);
      check("t3_reads", 32'(rd_n), 3);
      check("t3_nwr", 32'(wa.size()), 1);
      check("t3_addr", 32'(wa[0]), 0);
      check("t3_data", 32'(wd[0]), 32'h5A);
      check("t3_overlap", 32'(both_n), 0);
      check_cursor("t3_cur", 0, 1);
      // 4: full screen clear
      wa.delete();
      wd.delete();
      send(8'h0C);
      check("t4_ready_low", 32'(in_ready), 0);
      wait_idle(cyc, bn);
      check("t4_busy_cycles", 32'(bn), 1280);
      check("t4_busy_span", 32'(cyc), 1280);
      check_blank_run("t4_clr", 0, 1280);
      check_cursor("t4_cur", 0, 0);
      check("t4_busy_after", 32'(busy), 0);
      // 5: backspace, carriage return, ignored code
      put(8'h0A);
      put(8'h0A);
      for (int i = 0; i < 5; i++) put(8'h61);
      check_cursor("t5_pre", 2, 5);
      wa.delete();
      wd.delete();
      put(8'h08);
      check("t5_bs_nwr", 32'(wa.size()), 1);
      check("t5_bs_addr", 32'(wa[0]), 132);
      check("t5_bs_data", 32'(wd[0]), 32'h20);
      check_cursor("t5_bs_cur", 2, 4);
      put(8'h01);
      check_cursor("t5_drop_cur", 2, 4);
      put(8'h0D);
      check_cursor("t5_cr_cur", 2, 0);
      wa.delete();
      wd.delete();
      put(8'h08);
      check("t5_bs0_nwr", 32'(wa.size()), 0);
      check_cursor("t5_bs0_cur", 2, 0);
      // 6: row wrap on line feed at the last row
      for (int i = 0; i < 17; i++) put(8'h0A);
      check_cursor("t6_pre", 19, 0);
      wa.delete();
      wd.delete();
      put(8'h0A);
      check_cursor("t6_wrap", 0, 0);
`ifdef CONSOLE_LINE_CLEAR_EN
      check_blank_run("t6_lineclr", 0, 64);
`else
      check("t6_nwr", 32'(wa.size()), 0);
`endif
      // reset in the middle of a full clear
      send(8'h0C);
      repeat (100) @(negedge clk);
      check("t6_mid_busy", 32'(busy), 1);
      reset = 1'b0;
      wa.delete();
      wd.delete();
      @(negedge clk);
      check_zero_outputs("t6_abort");
      reset = 1'b1;
      repeat (10) @(negedge clk);
      check("t6_abort_nwr", 32'(wa.size()), 0);
      check("t6_abort_ready", 32'(in_ready), 1);
      check("t6_abort_busy", 32'(busy), 0);
      check("t6_overlap", 32'(both_n), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
